// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between a master (or the bus fabric) and the SRAM slave.
// hready is the bus-level ready that the fabric returns to every slave.
interface ahb_lite_sram_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic              hreadyout;
    logic [DATA_W-1:0] hrdata;
    logic              hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
        input  hreadyout, hrdata, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
        output hreadyout, hrdata, hresp
    );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: byte-lane writes, optional wait states, two-cycle ERROR
// response for out-of-range, oversized or misaligned transfers.
module ahb_lite_sram_slave #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                 hclk,
    input  logic                 hreset,
    ahb_lite_sram_slave_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HI_W  = ADDR_W - OFF_W;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DONE,
        ERR1,
        ERR2
    } state_t;

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic              load;
    logic              hreadyout, hresp;

    logic [IDX_W-1:0]  idx_q;
    logic [OFF_W-1:0]  off_q;
    logic [2:0]        size_q;
    logic              write_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [NB-1:0]     be;

    logic              accept;
    logic              xfer_err;
    logic              oob, too_big, misalign;
    logic [HI_W-1:0]   word_in;
    logic              commit, rd_done;

    // Burst type and protection are accepted for protocol completeness only.
    logic unused_sideband;
    assign unused_sideband = ^{bus.hburst, bus.hprot};

    assign accept  = bus.hsel && bus.htrans[1];
    assign word_in = bus.haddr[ADDR_W-1:OFF_W];
    assign oob     = (word_in >= HI_W'(DEPTH));
    assign too_big = (bus.hsize > 3'(OFF_W));

    always_comb begin
        misalign = 1'b0;
        for (int i = 0; i < OFF_W; i++) begin
            if (i < int'(bus.hsize) && bus.haddr[i]) misalign = 1'b1;
        end
    end

    assign xfer_err = oob || too_big || misalign;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        hreadyout  = 1'b1;
        hresp      = 1'b0;
        case (state)
            IDLE, DONE, ERR2: begin
                hresp = (state == ERR2);
                // With hready low another slave owns the data phase: hold still.
                if (bus.hready) begin
                    if (accept) begin
                        load = 1'b1;
                        if (xfer_err) begin
                            state_next = ERR1;
                        end else if (WAIT_STATES > 0) begin
                            state_next = WAIT;
                            cnt_next   = 4'(WAIT_STATES - 1);
                        end else begin
                            state_next = DONE;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            WAIT: begin
                hreadyout = 1'b0;
                if (cnt == 4'd0) state_next = DONE;
                else             cnt_next   = cnt - 4'd1;
            end
            ERR1: begin
                hreadyout  = 1'b0;
                hresp      = 1'b1;
                state_next = ERR2;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
        end else if (load) begin
            idx_q   <= bus.haddr[OFF_W +: IDX_W];
            off_q   <= bus.haddr[OFF_W-1:0];
            size_q  <= bus.hsize;
            write_q <= bus.hwrite;
        end
    end

    // Lanes [off, off + 2^size) of the captured transfer, little-endian.
    always_comb begin
        be = '0;
        for (int i = 0; i < NB; i++) begin
            be[i] = (i >= int'(off_q)) && (i < int'(off_q) + (1 << size_q));
        end
    end

    // The data phase only completes when the bus is ready, so a DONE held by
    // hready=0 neither commits nor captures until it really ends.
    assign commit  = (state == DONE) && write_q && bus.hready;
    assign rd_done = (state == DONE) && !write_q && bus.hready;

    // NOTE: the array has no reset; contents survive hreset and only the
    // control path is cleared, which also drops any write still pending.
    always_ff @(posedge hclk) begin
        if (commit) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[idx_q][8*i +: 8] <= bus.hwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset)       rdata_q <= '0;
        else if (rd_done) rdata_q <= mem[idx_q];
    end

    // The array is read asynchronously, so a read right after a write to the
    // same word already sees the committed bytes without a bypass path.
    assign bus.hrdata    = ((state == DONE) && !write_q) ? mem[idx_q] : rdata_q;
    assign bus.hreadyout = hreadyout;
    assign bus.hresp     = hresp;
endmodule

// File: doc/ahb_lite_sram_slave.md
AHB_LITE_SRAM_SLAVE -- requirements
Module: ahb_lite_sram_slave

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_W, 32, haddr width
- DATA_W, 32, data bus width; one of 32 or 64
- DEPTH, 1024, memory depth in DATA_W words
- WAIT_STATES, 0, wait cycles inserted per OKAY transfer; range 0-15
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- hclk, in, 1, single clock; all logic on its rising edge
- hreset, in, 1, asynchronous active-high reset
- hsel, in, 1, slave select
- haddr, in, ADDR_W, byte address
- htrans, in, 2, IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite, in, 1, 1=write
- hsize, in, 3, transfer size, log2 of bytes
- hburst, in, 3, burst type; accepted, no effect
- hprot, in, 4, protection; accepted, no effect
- hwdata, in, DATA_W, write data, valid in the data phase
- hready, in, 1, bus-level ready; qualifies the address phase
- hreadyout, out, 1, slave ready
- hrdata, out, DATA_W, read data
- hresp, out, 1, 0=OKAY, 1=ERROR

Function
REQ-003 An address phase SHALL be accepted only when hsel=1, hready=1 and htrans[1]=1; haddr, hwrite and hsize SHALL be registered at acceptance.
REQ-004 IDLE or BUSY, when selected with hready=1, SHALL get a zero-wait OKAY response (hreadyout=1, hresp=0) and no memory access.
REQ-005 FSM states SHALL be IDLE, WAIT, DONE, ERR1 and ERR2.
- IDLE -> WAIT on a valid accept if WAIT_STATES>0, or -> DONE if WAIT_STATES=0.
- Any accept with an error condition -> ERR1.
REQ-006 In WAIT, hreadyout SHALL be 0 for exactly WAIT_STATES cycles, counted by a down-counter loaded at acceptance; at count 0 the FSM SHALL go to DONE.
REQ-007 In DONE, hreadyout SHALL be 1 and hresp SHALL be 0. The FSM SHALL then go to IDLE, or accept a new address phase in the same cycle (back-to-back pipelining, no bubble).
REQ-008 A transfer SHALL be an error when any of these holds; it SHALL get no memory access.
- The word index is >= DEPTH.
- 2^hsize > DATA_W/8.
- haddr is not aligned to 2^hsize.
REQ-009 The error response SHALL take two cycles: ERR1 with hreadyout=0, hresp=1; then ERR2 with hreadyout=1, hresp=1. A new address phase accepted in ERR2 SHALL be processed normally.
REQ-010 Writes SHALL commit on the rising edge that ends DONE. Only the byte lanes selected by haddr[log2(DATA_W/8)-1:0] and hsize SHALL be updated, little-endian.
REQ-011 For reads, hrdata SHALL present the full addressed word in DONE and hold its last value otherwise.
REQ-012 A read whose data phase directly follows a write to the same word SHALL return the newly written bytes.
REQ-013 While hready=0 and hreadyout=1 (another slave is stalling), the block SHALL sample nothing and change no state.
REQ-014 hburst SHALL NOT change behaviour; each SEQ beat SHALL be a separate transfer with its own WAIT_STATES.

Reset
REQ-015 hreset=1 SHALL immediately force these values, independent of hclk:
- FSM state IDLE, counter 0
- hreadyout=1, hresp=0, hrdata=0
REQ-016 Reset asserted mid-transfer SHALL discard the pending write. The memory array SHALL NOT be cleared by reset.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- V1, WAIT_STATES=0: NONSEQ write 0xDEADBEEF to 0x10, then NONSEQ read of 0x10 back-to-back -> read DONE shows hrdata=0xDEADBEEF, hreadyout never low.
- V2, WAIT_STATES=3: read of 0x20 -> hreadyout low exactly 3 cycles, then 1 with hresp=0.
- V3: word write 0x00000000 to 0x40, then byte write 0xAB at 0x42 (hsize=0) -> read of 0x40 returns 0x00AB0000.
- V4: access at byte 4*DEPTH -> ERR1 (hreadyout=0, hresp=1), ERR2 (hreadyout=1, hresp=1); memory unchanged.
- V5: misaligned halfword at 0x41 -> two-cycle ERROR; a following valid read in ERR2 completes OKAY.
- V6, WAIT_STATES=5: assert hreset during WAIT of a write -> hreadyout=1, hresp=0 immediately; later read of that address returns the old data.
